// File: rtl/word_sum_pkg.sv
// Shared types and helpers for the word_sum_seq block: DNA digit encoding,
// FSM state enum and the GC-digit predicate.
package word_sum_pkg;

    typedef logic [1:0] dna_digit_t;

    localparam dna_digit_t BASE_A = 2'd0;
    localparam dna_digit_t BASE_C = 2'd1;
    localparam dna_digit_t BASE_G = 2'd2;
    localparam dna_digit_t BASE_T = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } ws_state_t;

    // C and G are the "GC" bases; A and T are not.
    function automatic logic is_gc(input dna_digit_t d);
        return (d == BASE_C) || (d == BASE_G);
    endfunction

endpackage

// File: rtl/word_chunk_sum.sv
// Combinational sum of P DNA digits and, when WORD_SUM_SEQ_GC_EN is defined,
// the count of those digits that are C or G.
module word_chunk_sum
    import word_sum_pkg::*;
#(
    parameter int P     = 1,
    parameter int SUM_W = 10
`ifdef WORD_SUM_SEQ_GC_EN
    ,
    parameter int CNT_W = 3
`endif
) (
    input  logic [2*P-1:0]   chunk,
    output logic [SUM_W-1:0] sum
`ifdef WORD_SUM_SEQ_GC_EN
    ,
    output logic [CNT_W-1:0] gc
`endif
);

    // Add the P zero-extended digits of the chunk.
    always_comb begin
        sum = '0;
        for (int k = 0; k < P; k++) begin
            sum = sum + SUM_W'(chunk[2*k +: 2]);
        end
    end

`ifdef WORD_SUM_SEQ_GC_EN
    // Count digits of the chunk that are C or G.
    always_comb begin
        gc = '0;
        for (int k = 0; k < P; k++) begin
            gc = gc + CNT_W'(is_gc(chunk[2*k +: 2]));
        end
    end
`endif

endmodule

// File: rtl/word_sum_seq.sv
// Sequential word digit-sum: accepts an N-digit DNA word over a valid/ready
// handshake, accumulates P digits per clock, and returns the digit sum (and
// optionally the GC count) over a second valid/ready handshake.
// Optional feature macro: WORD_SUM_SEQ_GC_EN builds the GC counter; without
// it gc_out is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. in_ready, out_valid and busy come from the state register only, so they
// never depend combinationally on in_valid or out_ready.
module word_sum_seq
    import word_sum_pkg::*;
#(
    parameter int N     = 4,
    parameter int P     = 1,
    parameter int SUM_W = 10,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   word_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic [CNT_W-1:0] gc_out,
    output logic             busy
);

    localparam int BEATS  = N / P;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Reject parameter sets the datapath cannot handle.
    if (N < 1) begin : g_bad_n
        $error("word_sum_seq: N must be at least 1");
    end
    if ((P < 1) || (N % P != 0)) begin : g_bad_p
        $error("word_sum_seq: N must be a multiple of P");
    end
    if (SUM_W < $clog2(3 * N + 1)) begin : g_bad_sum_w
        $error("word_sum_seq: SUM_W too narrow for 3*N");
    end

    ws_state_t          state;
    ws_state_t          state_nxt;
    logic [2*N-1:0]     shift_reg;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [SUM_W-1:0]   sum_acc;
    logic [SUM_W-1:0]   chunk_sum;
    logic               accept;
    logic               last_beat;

    assign accept    = in_valid && (state == IDLE);
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum_out   = sum_acc;

`ifdef WORD_SUM_SEQ_GC_EN
    logic [CNT_W-1:0] gc_acc;
    logic [CNT_W-1:0] chunk_gc;

    word_chunk_sum #(
        .P     (P),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_chunk (
        .chunk (shift_reg[2*P-1:0]),
        .sum   (chunk_sum),
        .gc    (chunk_gc)
    );

    // GC accumulator: cleared on accept, advanced once per SUM beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc_acc <= '0;
        end else if (accept) begin
            gc_acc <= '0;
        end else if (state == SUM) begin
            gc_acc <= gc_acc + chunk_gc;
        end
    end

    assign gc_out = gc_acc;
`else
    word_chunk_sum #(
        .P     (P),
        .SUM_W (SUM_W)
    ) u_chunk (
        .chunk (shift_reg[2*P-1:0]),
        .sum   (chunk_sum)
    );

    assign gc_out = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SUM;
            SUM:     if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the word on accept, then shift out P digits per beat
    // while summing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            beat_cnt  <= '0;
            sum_acc   <= '0;
        end else if (accept) begin
            shift_reg <= word_in;
            beat_cnt  <= '0;
            sum_acc   <= '0;
        end else if (state == SUM) begin
            shift_reg <= shift_reg >> (2 * P);
            beat_cnt  <= beat_cnt + BEAT_W'(1);
            sum_acc   <= sum_acc + chunk_sum;
        end
    end

endmodule

// File: tb/tb_word_sum_seq.sv
// Directed bench for word_sum_seq: one N=4/P=1 instance and one N=8/P=2
// instance sharing a clock. Inputs are driven and outputs sampled 1ns after
// the rising edge.
module tb_word_sum_seq;
    import word_sum_pkg::*;

`ifdef WORD_SUM_SEQ_GC_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    // Instance A: N=4, P=1
    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_word_in;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [9:0]  a_sum_out;
    logic [2:0]  a_gc_out;
    logic        a_busy;

    // Instance B: N=8, P=2
    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_word_in;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [9:0]  b_sum_out;
    logic [3:0]  b_gc_out;
    logic        b_busy;

    word_sum_seq #(.N(4), .P(1), .SUM_W(10)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .word_in   (a_word_in),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sum_out   (a_sum_out),
        .gc_out    (a_gc_out),
        .busy      (a_busy)
    );

    word_sum_seq #(.N(8), .P(2), .SUM_W(10)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .word_in   (b_word_in),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sum_out   (b_sum_out),
        .gc_out    (b_gc_out),
        .busy      (b_busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_gc(input int v);
        return GC_EN ? v : 0;
    endfunction

    // Driver: wait (bounded) for in_ready, present the word for one edge.
    task automatic accept_a(input logic [7:0] word);
        int n;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a_in_valid = 1'b1;
        a_word_in  = word;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    // Count cycles after an accept until out_valid (50 means timed out).
    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_a();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_word_in = 8'hFF; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_word_in = 16'hFFFF; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     a_in_ready, a_out_valid, a_busy);
        end
        checks++;
        if (a_sum_out !== 10'd0 || a_gc_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: sum=%0d gc=%0d, required 0 0", a_sum_out, a_gc_out);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_sum_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_b: in_ready=%b out_valid=%b sum=%0d, required 1 0 0",
                     b_in_ready, b_out_valid, b_sum_out);
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        accept_a(8'b01_00_00_10);
        checks++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b in_ready=%b, required 1 0", a_busy, a_in_ready);
        end
        wait_valid_a(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if (a_sum_out !== 10'd3) begin
            errors++;
            $display("FAIL basic_sum: got %0d, required 3", a_sum_out);
        end
        checks++;
        if (a_gc_out !== 3'(exp_gc(2))) begin
            errors++;
            $display("FAIL basic_gc: got %0d, required %0d", a_gc_out, exp_gc(2));
        end
        release_a();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                     a_out_valid, a_in_ready, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int t1;
        int t2;
        a_out_ready = 1'b1;
        accept_a(8'b10_00_01_11);
        t1 = cyc;
        wait_valid_a(lat);
        checks++;
        if (a_sum_out !== 10'd6 || a_gc_out !== 3'(exp_gc(2))) begin
            errors++;
            $display("FAIL b2b_first: sum=%0d gc=%0d, required 6 %0d",
                     a_sum_out, a_gc_out, exp_gc(2));
        end
        accept_a(8'b11_01_10_10);
        t2 = cyc;
        checks++;
        if (t2 - t1 !== 6) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles between accepts, required 6", t2 - t1);
        end
        wait_valid_a(lat);
        checks++;
        if (a_sum_out !== 10'd8 || a_gc_out !== 3'(exp_gc(3))) begin
            errors++;
            $display("FAIL b2b_second: sum=%0d gc=%0d, required 8 %0d",
                     a_sum_out, a_gc_out, exp_gc(3));
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_one_cycle: out_valid=%b, required 0", a_out_valid);
        end
        a_out_ready = 1'b0;
    endtask

    task automatic test_extremes();
        int lat;
        accept_a(8'hFF);
        wait_valid_a(lat);
        checks++;
        if (a_sum_out !== 10'd12 || a_gc_out !== 3'd0) begin
            errors++;
            $display("FAIL all_t: sum=%0d gc=%0d, required 12 0", a_sum_out, a_gc_out);
        end
        release_a();
        accept_a(8'h00);
        wait_valid_a(lat);
        checks++;
        if (a_sum_out !== 10'd0 || a_gc_out !== 3'd0 || lat !== 4) begin
            errors++;
            $display("FAIL all_a: sum=%0d gc=%0d lat=%0d, required 0 0 4",
                     a_sum_out, a_gc_out, lat);
        end
        release_a();
    endtask

    task automatic test_backpressure();
        int lat;
        accept_a(8'b10_00_01_11);
        wait_valid_a(lat);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_word_in  = 8'hFF;
            @(posedge clk); #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_sum_out !== 10'd6 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b sum=%0d in_ready=%b, required 1 6 0",
                         i, a_out_valid, a_sum_out, a_in_ready);
            end
        end
        a_in_valid = 1'b0;
        release_a();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_sum_out !== 10'd6) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b sum=%0d, required 0 1 0 6",
                     a_out_valid, a_in_ready, a_busy, a_sum_out);
        end
    endtask

    task automatic test_wide();
        int lat;
        b_in_valid = 1'b1;
        b_word_in  = 16'hFFFF;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL wide_latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if (b_sum_out !== 10'd24 || b_gc_out !== 4'd0) begin
            errors++;
            $display("FAIL wide_result: sum=%0d gc=%0d, required 24 0", b_sum_out, b_gc_out);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wide_release: out_valid=%b in_ready=%b, required 0 1",
                     b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        // Abort two beats into SUM.
        accept_a(8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || dut_a.state !== IDLE || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_sum: out_valid=%b state=%0d in_ready=%b busy=%b, required 0 0 1 0",
                     a_out_valid, dut_a.state, a_in_ready, a_busy);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_recover_ready: in_ready=%b, required 1", a_in_ready);
        end
        accept_a(8'b01_00_00_10);
        wait_valid_a(lat);
        checks++;
        if (a_sum_out !== 10'd3 || lat !== 4) begin
            errors++;
            $display("FAIL reset_recover_sum: sum=%0d lat=%0d, required 3 4", a_sum_out, lat);
        end
        // Abort while holding a result in DONE: out_valid must drop without an edge.
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_sum_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_in_done: out_valid=%b sum=%0d, required 0 0", a_out_valid, a_sum_out);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_word_in = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_word_in = '0; b_out_ready = 1'b0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_backpressure();
        test_wide();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_sum_seq.md
# word_sum_seq

Sequential, parametrised successor to the combinational word digit-sum block. It accepts an N-digit word of 2-bit DNA digits (A=0, C=1, G=2, T=3) over a valid/ready handshake and accumulates P digits per clock. It returns the digit sum and, optionally, the GC count over a second valid/ready handshake. It sits between the word source and downstream scoring logic, and trades latency for adder area when N is large.

## Interface
Parameters:
- N, 4, number of digits per word; must be at least 1.
- P, 1, digits consumed per cycle; N % P == 0 is required (elaboration error otherwise).
- SUM_W, 10, sum_out width; must be ≥ $clog2(3*N+1) (elaboration error otherwise).
- CNT_W, $clog2(N+1), gc_out width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  word_in is valid.
- in_ready  out  1  block can accept a word; equals 1 exactly when the state is IDLE.
- word_in  in  2N  input word; digit k is word_in[2k+1:2k]; digit 0 is processed first.
- out_valid  out  1  sum_out and gc_out are valid.
- out_ready  in  1  downstream accepts the result.
- sum_out  out  SUM_W  sum of all N digits.
- gc_out  out  CNT_W  count of digits equal to 1 or 2.
- busy  out  1  1 when the state is SUM or DONE.

## Operation
- FSM states: IDLE, SUM, DONE.
- Reset: state=IDLE; shift register, beat counter, sum_out and gc_out = 0; out_valid=0; busy=0; in_ready=1. Inputs are ignored while rst is high.
- IDLE: on in_valid && in_ready, latch word_in into the shift register, clear the accumulators and the beat counter, then go to SUM.
- SUM:
  - Each cycle, add the low P digits to sum_acc and add their GC count to gc_acc.
  - Shift the register right by 2P bits and increment the beat counter.
  - On the beat N/P-1, go to DONE.
- DONE:
  - out_valid=1.
  - sum_out and gc_out hold stable until out_ready=1; on that edge go to IDLE with out_valid=0.
  - in_ready=0 here, so a word cannot be accepted in the same cycle as a result is released.
- sum_out and gc_out always show the accumulator registers. They are meaningful only while out_valid=1.
- Arithmetic is unsigned. Digits are zero-extended to SUM_W. Overflow is impossible given the SUM_W constraint.
- Reset asserted mid-operation (SUM or DONE) aborts immediately: the word is lost, state returns to IDLE, and out_valid drops asynchronously.
- in_valid while not in IDLE is ignored. The source must hold the word, since in_ready=0.

## Timing
- If a word is accepted at rising edge T0, out_valid rises after edge T0+N/P, which is N/P cycles after the accept edge.
- Minimum word period is N/P+2 cycles: 1 cycle in IDLE, N/P cycles in SUM, and at least 1 cycle in DONE.
- With out_ready held at 1, DONE lasts exactly 1 cycle.
- in_ready, busy and out_valid are decoded from the state register only. They have no combinational path from in_valid or out_ready.

## Configuration
- WORD_SUM_SEQ_GC_EN defined:
  - the GC comparators and gc_acc are built;
  - gc_out carries the GC count.
- Not defined:
  - the GC logic is omitted;
  - gc_out is tied to 0 at all times;
  - the port list is unchanged.

## Structure
- Shared package word_sum_pkg:
  - typedef dna_digit_t (logic [1:0]);
  - constants BASE_A=0, BASE_C=1, BASE_G=2, BASE_T=3;
  - the FSM enum ws_state_t {IDLE, SUM, DONE};
  - function is_gc(dna_digit_t).
- One sub-module, word_chunk_sum: a combinational sum of P digits plus their GC count. It is instantiated once and fed the low 2P bits of the shift register.

## Test plan
- N=4, P=1, word 8'b01_00_00_10: sum_out=3 and gc_out=2, with out_valid rising 4 cycles after accept.
- N=4, P=1, words 8'b10_00_01_11 then 8'b11_01_10_10 back-to-back with out_ready=1:
  - sums are 6 then 8, GC counts are 2 then 3;
  - the second accept occurs 6 cycles after the first.
- N=4, P=1, all-T word 8'hFF: sum_out=12, gc_out=0. All-A word 8'h00: sum_out=0, gc_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_valid stays 1 with sum_out unchanged, in_ready stays 0, and a presented in_valid is ignored.
- N=8, P=2, word 16'hFFFF: out_valid rises 4 cycles after accept with sum_out=24 and gc_out=0.
- Assert rst 2 cycles into SUM: out_valid=0 and state=IDLE immediately. After rst deasserts, in_ready=1 and a fresh word 8'b01_00_00_10 yields sum_out=3.
